arr_out_drain: RTL
==================

# arr_out_drain

Output stage for the 16x16 systolic array, directly downstream of the array controller. It captures the 16 skewed column partial sums leaving the array and realigns them into one row. It accumulates rows across input-channel passes, then requantizes each result to 8 bits. Finished rows are written serially into the output SRAM through a single-port, active-low write interface.

## Interface
- N, 16, array columns
- PSUM_W, 24, signed partial-sum width per column from the array
- ACC_W, 32, signed accumulator width
- ADDR_W, 16, output SRAM address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; loads cfg_*, clears all state, begins a layer
- cfg_base_addr  in  ADDR_W  first output SRAM address
- cfg_rows  in  16  number of result rows to write before done
- cfg_shift  in  5  arithmetic right shift applied before saturation
- cfg_relu  in  1  clamp negative results to 0
- psum_in  in  N*PSUM_W  column i occupies bits [i*PSUM_W +: PSUM_W]
- psum_valid  in  N  per-column valid; column i arrives i cycles after column 0
- pass_first  in  1  sampled with psum_valid[0]; row overwrites accumulators
- pass_last  in  1  sampled with psum_valid[0]; row is final and is drained
- out_wen  out  1  active-low SRAM write enable
- out_addr  out  ADDR_W  SRAM address
- out_data  out  8  signed requantized result
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse when cfg_rows rows are written
- err_overrun  out  1  sticky; column re-captured before its row completed
- err_overflow  out  1  sticky; final row ready while drain bank occupied

## Operation
- Capture: cap[i] <= psum_in[i] and mask[i] <= 1 on psum_valid[i]. When mask is complete (this cycle's valids included), row_done pulses for one cycle and mask clears. psum_valid[i] with mask[i] already set sets err_overrun; the value is dropped.
- Flags: pass_first/pass_last are latched on psum_valid[0] and held for that row.
- Accumulate (cycle after row_done): acc[i] <= first ? sext(cap[i]) : acc[i] + sext(cap[i]), wrapping at ACC_W.
- Requantize: q = acc >>> cfg_shift. If cfg_relu and q < 0, then q = 0. Saturate to [-128, 127].
- Drain bank: when a last row's accumulate completes, the requantized row loads into the drain bank if the drain is idle. If the drain is busy, err_overflow sets and the row is dropped. Accumulators are unaffected either way.
- Drain FSM:
  - DR_IDLE -> DR_WRITE on load.
  - DR_WRITE emits column 0..N-1, one per cycle; out_addr increments by 1 per write and is continuous across rows.
  - After column N-1: rows_written += 1, then DR_IDLE.
- Done: pulses when rows_written reaches cfg_rows; busy drops the same cycle. Later psums are ignored until the next start.
- start while busy: aborts the drain and clears mask, acc, rows_written and error flags; the new config applies.
- Inputs are ignored when busy = 0.

## Timing
- Reset values:
  - out_wen = 1, out_addr = 0, out_data = 0.
  - busy = 0, done = 0, err_* = 0; FSM in DR_IDLE; mask = 0.
- Latency: psum_valid[N-1] sampled at edge E; acc updated at E+1; drain bank loaded at E+2. The first write (out_wen = 0, addr = base + 16*r, column 0) is driven after E+2, and the SRAM samples it at E+3. Column N-1 is sampled at E+18.
- All outputs are registered. out_data/out_addr are held at their last values while out_wen = 1.
- A row may complete in the same cycle the drain writes its last column: the load is accepted, giving back-to-back rows with no bubble and no overflow.
- rst mid-drain: out_wen = 1 on the next edge; no partial write continues.

## Test plan
- Reset, start (base = 0x0100, rows = 1, shift = 0, relu = 0), one skewed row with pass_first = pass_last = 1, psum[i] = i -> writes to 0x0100..0x010F with data 0..15; done on the cycle after the last write.
- Three passes of psum[i] = 100 (first, mid, last), shift = 2 -> all 16 outputs = 75.
- Saturation/ReLU: acc = -1000 with relu = 0 -> -128; with relu = 1 -> 0; acc = 40000, shift = 4 -> 127.
- psum_valid[3] pulsed twice within one row -> err_overrun = 1; the row still completes on its remaining columns.
- Two last rows completing 5 cycles apart -> err_overflow = 1, only the first row is written; rows completing exactly 16 cycles apart -> both written at consecutive addresses with no error.
- rst asserted mid-drain at column 7 -> out_wen = 1 next cycle, all outputs at reset values; a restart writes again from base.

Source files
------------

// File: rtl/arr_out_drain_if.sv
// Array-side psum bus and SRAM-side write port of the systolic output stage.
// The design uses the slave view; whoever feeds rows and watches writes uses master.
interface arr_out_drain_if #(
  parameter int N      = 16,
  parameter int PSUM_W = 24,
  parameter int ADDR_W = 16
);
  logic [N*PSUM_W-1:0] psum_in;
  logic [N-1:0]        psum_valid;
  logic                pass_first;
  logic                pass_last;
  logic                out_wen;
  logic [ADDR_W-1:0]   out_addr;
  logic [7:0]          out_data;

  modport master (
    output psum_in, psum_valid, pass_first, pass_last,
    input  out_wen, out_addr, out_data
  );

  modport slave (
    input  psum_in, psum_valid, pass_first, pass_last,
    output out_wen, out_addr, out_data
  );
endinterface

// File: rtl/arr_out_drain.sv
// Systolic array output stage: deskews column psums, accumulates across passes,
// requantizes to int8 and writes finished rows serially into the output SRAM.
module arr_out_drain #(
  parameter int N      = 16,
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_rows,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  arr_out_drain_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic              err_overflow
);
  localparam int CW = $clog2(N);

  typedef enum logic {DR_IDLE, DR_WRITE} dr_state_t;

  dr_state_t state_q, state_d;

  logic [CW-1:0]            col_q;
  logic [15:0]              rows_cfg_q, rows_written_q;
  logic [4:0]               shift_q;
  logic                     relu_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [N-1:0]             mask_q;
  logic signed [PSUM_W-1:0] cap_q [N];
  logic                     row_first_q, row_last_q, row_done_q;
  logic signed [ACC_W-1:0]  acc_q [N];
  logic                     acc_valid_q, acc_last_q;
  logic signed [7:0]        bank_q [N];
  logic signed [7:0]        q_row [N];

  logic [N-1:0]      accepted, clashed;
  logic              row_complete, last_col, finishing, drain_free, row_ready, load, emit;
  logic signed [7:0] emit_data;

  function automatic logic signed [7:0] requant(input logic signed [ACC_W-1:0] a,
                                                input logic [4:0] sh, input logic relu);
    logic signed [ACC_W-1:0] s;
    s = a >>> sh;
    if (relu && s < 0) s = '0;
    if (s > 127) return 8'sh7F;
    if (s < -128) return 8'sh80;
    return s[7:0];
  endfunction

  // A column that arrives while its mask bit is still set belongs to no row: drop it.
  always_comb begin
    accepted     = bus.psum_valid & ~mask_q & {N{busy}};
    clashed      = bus.psum_valid & mask_q & {N{busy}};
    row_complete = busy && ((mask_q | accepted) == {N{1'b1}});
  end

  always_comb begin
    for (int i = 0; i < N; i++) q_row[i] = requant(acc_q[i], shift_q, relu_q);
  end

  // The drain can take a new row on the very edge its last column is written.
  assign last_col   = (state_q == DR_WRITE) && (col_q == CW'(N - 1));
  assign finishing  = last_col && (rows_written_q + 16'd1 == rows_cfg_q);
  assign drain_free = (state_q == DR_IDLE) || last_col;
  assign row_ready  = busy && acc_valid_q && acc_last_q;
  assign load       = row_ready && drain_free && !finishing;

  always_ff @(posedge clk) begin
    if (rst) state_q <= DR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DR_IDLE:  if (load) state_d = DR_WRITE;
      DR_WRITE: if (last_col && !load) state_d = DR_IDLE;
      default:  state_d = DR_IDLE;
    endcase
    if (start) state_d = DR_IDLE;
  end

  always_comb begin
    emit      = 1'b0;
    emit_data = bank_q[0];
    if (load) begin
      emit      = 1'b1;
      emit_data = q_row[0];
    end else if (state_q == DR_WRITE && !last_col) begin
      emit      = 1'b1;
      emit_data = bank_q[col_q + CW'(1)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      err_overrun    <= 1'b0;
      err_overflow   <= 1'b0;
      bus.out_wen    <= 1'b1;
      bus.out_addr   <= '0;
      bus.out_data   <= '0;
      mask_q         <= '0;
      row_first_q    <= 1'b0;
      row_last_q     <= 1'b0;
      row_done_q     <= 1'b0;
      acc_valid_q    <= 1'b0;
      acc_last_q     <= 1'b0;
      col_q          <= '0;
      rows_written_q <= '0;
      rows_cfg_q     <= '0;
      shift_q        <= '0;
      relu_q         <= 1'b0;
      wr_addr_q      <= '0;
    end else if (start) begin
      busy           <= 1'b1;
      done           <= 1'b0;
      err_overrun    <= 1'b0;
      err_overflow   <= 1'b0;
      bus.out_wen    <= 1'b1;
      mask_q         <= '0;
      row_first_q    <= 1'b0;
      row_last_q     <= 1'b0;
      row_done_q     <= 1'b0;
      acc_valid_q    <= 1'b0;
      acc_last_q     <= 1'b0;
      col_q          <= '0;
      rows_written_q <= '0;
      rows_cfg_q     <= cfg_rows;
      shift_q        <= cfg_shift;
      relu_q         <= cfg_relu;
      wr_addr_q      <= cfg_base_addr;
    end else begin
      done        <= finishing;
      if (finishing) busy <= 1'b0;
      mask_q      <= row_complete ? '0 : (mask_q | accepted);
      if (|clashed) err_overrun <= 1'b1;
      if (accepted[0]) begin
        row_first_q <= bus.pass_first;
        row_last_q  <= bus.pass_last;
      end
      row_done_q  <= row_complete;
      acc_valid_q <= row_done_q;
      acc_last_q  <= row_last_q;
      if (row_ready && !drain_free) err_overflow <= 1'b1;
      if (last_col) rows_written_q <= rows_written_q + 16'd1;
      if (load)                                     col_q <= '0;
      else if (state_q == DR_WRITE && !last_col)    col_q <= col_q + CW'(1);
      bus.out_wen <= ~emit;
      if (emit) begin
        bus.out_addr <= wr_addr_q;
        bus.out_data <= emit_data;
        wr_addr_q    <= wr_addr_q + ADDR_W'(1);
      end
    end
  end

  // Capture values need no reset: the mask decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
    end else if (row_done_q) begin
      for (int i = 0; i < N; i++)
        acc_q[i] <= row_first_q ? ACC_W'(cap_q[i]) : acc_q[i] + ACC_W'(cap_q[i]);
    end
    for (int i = 0; i < N; i++)
      if (accepted[i]) cap_q[i] <= bus.psum_in[i*PSUM_W +: PSUM_W];
    if (load)
      for (int i = 0; i < N; i++) bank_q[i] <= q_row[i];
  end
endmodule
